// File: rtl/reg_file_pkg.sv
// Shared defaults and bus-slicing helpers for the multi-port register file.
// The slice macro picks element idx of width w out of a flattened port bus.
package reg_file_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int ZERO_ADDR    = 0;
endpackage

`ifndef RF_SLICE
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for multi-cycle producers; a reserve in the same
// cycle as a completing write wins, since it belongs to a newer producer.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          clr_en,
    input  logic [2*AW-1:0]     clr_reg,
    input  logic                set_en,
    input  logic [AW-1:0]       set_reg,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        for (int p = 0; p < 2; p++) begin
            if (clr_en[p]) busy_next[`RF_SLICE(clr_reg, p, AW)] = 1'b0;
        end
        if (set_en && !(ZERO_REG && set_reg == AW'(ZERO_ADDR))) busy_next[set_reg] = 1'b1;
        if (ZERO_REG) busy_next[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) busy <= '0;
        else       busy <= busy_next;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports (port 1 wins on conflict),
// NUM_RD combinational read ports with optional same-cycle bypass and busy flags.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_RD*AW-1:0]     read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic [1:0]               reg_write,
    input  logic [2*AW-1:0]          write_reg,
    input  logic [2*DATA_W-1:0]      write_data,
    input  logic                     reserve_en,
    input  logic [AW-1:0]            reserve_reg
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .rstn    (rstn),
        .clr_en  (reg_write),
        .clr_reg (write_reg),
        .set_en  (reserve_en),
        .set_reg (reserve_reg),
        .busy    (busy)
    );

    // Port 1 is applied last so it overwrites port 0 on an address conflict.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (reg_write[p] && !(ZERO_REG && `RF_SLICE(write_reg, p, AW) == AW'(ZERO_ADDR)))
                    regs[`RF_SLICE(write_reg, p, AW)] <= `RF_SLICE(write_data, p, DATA_W);
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic              hit0;
        logic              hit1;
        logic [DATA_W-1:0] rd_val;

        assign addr = `RF_SLICE(read_reg, k, AW);
        assign hit0 = BYPASS && rstn && reg_write[0] && (`RF_SLICE(write_reg, 0, AW) == addr);
        assign hit1 = BYPASS && rstn && reg_write[1] && (`RF_SLICE(write_reg, 1, AW) == addr);

        always_comb begin
            if (ZERO_REG && addr == AW'(ZERO_ADDR)) rd_val = '0;
            else if (hit1)                          rd_val = `RF_SLICE(write_data, 1, DATA_W);
            else if (hit0)                          rd_val = `RF_SLICE(write_data, 0, DATA_W);
            else                                    rd_val = regs[addr];
        end

        assign `RF_SLICE(read_data, k, DATA_W) = rd_val;
        // A forwarded value is already available, so it never reads as busy.
        assign read_busy[k] = busy[addr] & ~(hit0 | hit1);
    end

endmodule
